// File: rtl/demux_1_to_2_16bit_buf_pkg.sv
// Shared constants for the 1-to-2 buffered stream demultiplexer.
// Holds the select encoding and the default geometry of the output FIFOs.
package demux_1_to_2_16bit_buf_pkg;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 2;

endpackage

// File: rtl/demux_1_to_2_16bit_buf_fifo_channel.sv
// One output channel: a small synchronous FIFO with an explicit occupancy counter.
// push/pop are qualified again here, so a push into a full FIFO or a pop from an empty one has no effect.
module demux_fifo_channel #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head_data,
  output logic [PTR_W:0]   occ
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_occ;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_occ == OCC_FULL);
  assign valid     = (r_occ != '0);
  assign occ       = r_occ;
  assign head_data = r_mem[r_rd_ptr];

  assign w_do_push = push && !full && !rst;
  assign w_do_pop  = pop && valid && !rst;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_occ <= r_occ + OCC_ONE;
        2'b01:   r_occ <= r_occ - OCC_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // NOTE: storage has no reset; valid is derived from r_occ, so stale words are never exposed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/demux_1_to_2_16bit_buf.sv
// Streaming 1-to-2 demux: each input word is steered by in_sel into one of two output FIFOs.
// in_ready looks only at the selected FIFO's full flag, never at the output readies.
module demux_1_to_2_16bit_buf
  import demux_1_to_2_16bit_buf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ready,
  output logic [PTR_W:0]   occ0,
  output logic [PTR_W:0]   occ1
);

  logic w_full0;
  logic w_full1;
  logic w_accept;
  logic w_push0;
  logic w_push1;
  logic w_pop0;
  logic w_pop1;

  assign in_ready = (in_sel == SEL_OUT1) ? !w_full1 : !w_full0;
  assign w_accept = in_valid && in_ready;
  assign w_push0  = w_accept && (in_sel == SEL_OUT0);
  assign w_push1  = w_accept && (in_sel == SEL_OUT1);
  assign w_pop0   = out0_valid && out0_ready;
  assign w_pop1   = out1_valid && out1_ready;

  demux_fifo_channel #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ch0 (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push0),
    .push_data (in_data),
    .full      (w_full0),
    .pop       (w_pop0),
    .valid     (out0_valid),
    .head_data (out0_data),
    .occ       (occ0)
  );

  demux_fifo_channel #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ch1 (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push1),
    .push_data (in_data),
    .full      (w_full1),
    .pop       (w_pop1),
    .valid     (out1_valid),
    .head_data (out1_data),
    .occ       (occ1)
  );

endmodule

// File: tb/tb_demux_1_to_2_16bit_buf.sv
// Bench for the buffered 1-to-2 demux: directed scenarios plus random readies,
// all outputs compared every cycle against two plain queues modelling the channel FIFOs.
module tb_demux_1_to_2_16bit_buf;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int PTR_W = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_ready;
  logic             out0_valid;
  logic [WIDTH-1:0] out0_data;
  logic             out0_ready;
  logic             out1_valid;
  logic [WIDTH-1:0] out1_data;
  logic             out1_ready;
  logic [PTR_W:0]   occ0;
  logic [PTR_W:0]   occ1;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  bit               last_acc;
  int               n_checks = 0;
  int               n_pass   = 0;

  always #5 clk = ~clk;

  demux_1_to_2_16bit_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_ready   (in_ready),
    .out0_valid (out0_valid),
    .out0_data  (out0_data),
    .out0_ready (out0_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready),
    .occ0       (occ0),
    .occ1       (occ1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Checks all outputs against the queues, then advances one clock and updates the queues.
  task automatic cycle();
    bit exp_rdy, acc, p0, p1;
    #1;
    exp_rdy = (in_sel ? q1.size() : q0.size()) < DEPTH;
    check("in_ready", in_ready, exp_rdy);
    check("out0_valid", out0_valid, q0.size() != 0);
    check("out1_valid", out1_valid, q1.size() != 0);
    if (q0.size() != 0) check("out0_data", out0_data, q0[0]);
    if (q1.size() != 0) check("out1_data", out1_data, q1[0]);
    check("occ0", occ0, q0.size());
    check("occ1", occ1, q1.size());
    acc = in_valid && exp_rdy && !rst;
    p0  = (q0.size() != 0) && out0_ready && !rst;
    p1  = (q1.size() != 0) && out1_ready && !rst;
    @(posedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
    end
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic s, input bit rand_rdy);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    last_acc = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (rand_rdy) begin
        out0_ready = 1'($urandom_range(0, 1));
        out1_ready = 1'($urandom_range(0, 1));
      end
      cycle();
      if (last_acc) break;
    end
    check("send_accepted", last_acc, 1);
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    in_sel   = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cycle();
    rst = 1'b0;
    cycle();

    // Basic steering with both sinks ready
    send(16'h1111, 1'b0, 1'b0);
    send(16'h2222, 1'b1, 1'b0);
    idle(3);

    // Stall sink 0 until the selected FIFO fills, then drain in order
    out0_ready = 1'b0;
    send(16'hA001, 1'b0, 1'b0);
    send(16'hA002, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 16'hA003; in_sel = 1'b0;
    repeat (3) cycle();
    check("a003_stalled", last_acc, 0);
    check("a003_full_occ0", occ0, 2);
    out0_ready = 1'b1;
    send(16'hA003, 1'b0, 1'b0);
    send(16'hB001, 1'b1, 1'b0);
    idle(4);

    // Full channel with simultaneous pop: freed slot usable only next cycle
    out1_ready = 1'b0;
    send(16'hC001, 1'b1, 1'b0);
    send(16'hC002, 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 16'hC003; in_sel = 1'b1; out1_ready = 1'b1;
    cycle();
    check("full_pop_no_accept", last_acc, 0);
    out1_ready = 1'b0;
    cycle();
    check("freed_slot_accept", last_acc, 1);
    in_valid = 1'b0;
    check("occ1_full_again", occ1, 2);
    out1_ready = 1'b1;
    idle(4);

    // Ten alternating words, then a longer random run for pointer wrap
    for (int i = 0; i < 10; i++) send(WIDTH'(i), 1'(i % 2), 1'b1);
    for (int i = 0; i < 40; i++) send(WIDTH'($urandom), 1'($urandom), 1'b1);
    out0_ready = 1'b1; out1_ready = 1'b1;
    idle(4);

    // Reset with words buffered in both channels
    out0_ready = 1'b0; out1_ready = 1'b0;
    send(16'hD001, 1'b0, 1'b0);
    send(16'hD002, 1'b0, 1'b0);
    send(16'hD003, 1'b1, 1'b0);
    check("pre_rst_occ0", occ0, 2);
    check("pre_rst_occ1", occ1, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("post_rst_occ0", occ0, 0);
    check("post_rst_occ1", occ1, 0);
    cycle();
    out0_ready = 1'b1; out1_ready = 1'b1;
    send(16'h5A5A, 1'b0, 1'b0);
    idle(2);

    // Held head word stays stable while sink 0 stalls
    out0_ready = 1'b0;
    send(16'hE001, 1'b0, 1'b0);
    repeat (5) cycle();
    check("hold_data", out0_data, 16'hE001);
    out0_ready = 1'b1;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
